// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - end-of-test monitor snooping regfile write-back
// Decides pass/fail/timeout from the done/pass/testnum register signature.
module test_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]     wb_wdata,
  input  logic                      retire,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [DATA_WIDTH-1:0]     fail_testnum,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      retire_count
);

  typedef enum logic [2:0] {S_RUN, S_SETTLE, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam longint CNT_MAX_L = (longint'(1) << CNT_WIDTH) - 1;
  // A limit the counter can never reach would alias after truncation, so it disables the watchdog.
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0) && ((longint'(TIMEOUT_CYCLES) - 1) <= CNT_MAX_L);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] DONE_A = REG_ADDR_WIDTH'(DONE_REG);
  localparam logic [REG_ADDR_WIDTH-1:0] PASS_A = REG_ADDR_WIDTH'(PASS_REG);
  localparam logic [REG_ADDR_WIDTH-1:0] TNUM_A = REG_ADDR_WIDTH'(TESTNUM_REG);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                state;
  logic [SCW-1:0]        settle_cnt;
  logic [DATA_WIDTH-1:0] pass_q;
  logic [DATA_WIDTH-1:0] tnum_q;

  logic active, wr_ok, done_evt, to_settle, verdict, wd_hit, to_timeout, count_en;

  assign active     = (state == S_RUN) || (state == S_SETTLE);
  assign wr_ok      = active && wb_we && (wb_waddr != '0);
  assign done_evt   = wr_ok && (wb_waddr == DONE_A) && (wb_wdata == ONE);
  assign to_settle  = (state == S_RUN) && done_evt;
  assign verdict    = (state == S_SETTLE) && (settle_cnt == '0);
  assign wd_hit     = WD_EN && (cycle_count == WD_LAST);
  // A done write or a settled verdict on the watchdog's terminal cycle takes priority.
  assign to_timeout = active && wd_hit && !to_settle && !verdict;
  assign count_en   = active && !to_timeout;

  assign fail_testnum = tnum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RUN;
      settle_cnt   <= '0;
      pass_q       <= '0;
      tnum_q       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (wr_ok && (wb_waddr == PASS_A)) pass_q <= wb_wdata;
      if (wr_ok && (wb_waddr == TNUM_A)) tnum_q <= wb_wdata;

      if (count_en) begin
        if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_WIDTH'(1);
        if (retire && (retire_count != CNT_MAX)) retire_count <= retire_count + CNT_WIDTH'(1);
      end

      case (state)
        S_RUN: begin
          if (to_settle) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end else if (to_timeout) begin
            state   <= S_TIMEOUT;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (verdict) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (pass_q == ONE) begin
              state <= S_PASS;
              pass  <= 1'b1;
            end else begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end
          end else if (to_timeout) begin
            state   <= S_TIMEOUT;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - SCW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
